decode_issue_unit: RTL
======================

// Module: decode_issue_unit
// PURPOSE
// - Decode stage feeding execute_unit: accepts 32-bit MIPS-style instruction words from fetch over
//   valid/ready, decodes R/I/J formats into execute_unit's control fields (alu_control, operand_1/2,
//   gpr_destination_address, immediate_value, reg_write), buffers decoded uops in a small FIFO and
//   issues them over valid/ready. Emits a one-cycle PC redirect to fetch when a jump is decoded.
// PARAMETERS
// - QUEUE_DEPTH  2   decoded-uop FIFO entries (power of 2, >=2)
// - PC_W         32  width of instr_pc / redirect_pc
// PORTS
// - clk                      in   1      rising-edge clock, sole clock domain
// - rst                      in   1      synchronous, active-high reset
// - instr_valid              in   1      fetch presents instr/instr_pc
// - instr_ready              out  1      decoder accepts this cycle
// - instr                    in   32     instruction word
// - instr_pc                 in   PC_W   address of instr
// - issue_valid              out  1      uop on issue fields valid
// - issue_ready              in   1      execute consumes uop this cycle
// - operand_1                out  5      rs field
// - operand_2                out  5      rt field (R-type only, else 0)
// - gpr_destination_address  out  32     {27'b0,rd} R / {27'b0,rt} I / {6'b0,target26} J
// - alu_control              out  4      0001 add, 0010 sub, 0011 addi, 0100 jump
// - reg_write                out  1      1 for add/sub/addi, 0 for jump
// - immediate_value          out  16     instr[15:0] for addi, else 0
// - redirect_valid           out  1      one-cycle pulse: fetch must jump to redirect_pc
// - redirect_pc              out  PC_W   {instr_pc[31:28], target26, 2'b00}
// - illegal_trap             out  1      sticky trap flag (ILLEGAL_TRAP_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Decode: op=instr[31:26]. op 000000 funct 100000 -> add; funct 100010 -> sub; op 001000 -> addi;
//   op 000010 -> jump. instr==32'h0 is NOP: accepted, never enqueued. Anything else is illegal.
// - Accept when instr_valid && instr_ready; instr_ready = (count < QUEUE_DEPTH) && state==RUN.
//   No bypass when full: full queue drops ready even if issue_ready is high that cycle.
// - Latency: uop accepted cycle N into empty queue drives issue_valid at N+1 (registered FIFO head).
// - issue_* fields stable while issue_valid && !issue_ready; entry pops on issue_valid && issue_ready.
// - Simultaneous push+pop: count unchanged, order preserved; read/write pointers wrap mod QUEUE_DEPTH.
// - When issue_valid=0, all issue fields read 0.
// - FSM: RUN -> FLUSH when a jump is accepted (cycle N). FLUSH lasts exactly cycle N+1:
//   redirect_valid=1, redirect_pc valid, instr_ready=0; upstream discards in-flight words.
//   FLUSH -> RUN at N+2. Jump uop itself is still enqueued and issued in order.
// - Illegal instruction in RUN: see CONFIGURATION.
// - Reset (any cycle, incl. mid-FLUSH or mid-stall): queue emptied, state RUN, instr_ready=1 from the
//   cycle after rst deasserts (0 while rst high), issue_valid=0, all issue fields 0,
//   redirect_valid=0, redirect_pc=0, illegal_trap=0.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined: illegal word accepted cycle N -> state TRAP, illegal_trap=1 from N+1,
//   instr_ready=0; queued older uops still drain to execute. Leaves TRAP only on rst.
// - ILLEGAL_TRAP_EN undefined: illegal word accepted and silently dropped (like NOP); no TRAP state,
//   illegal_trap tied 0.
// TESTING
// - Reset, then instr=32'h00321820 pc=0 -> next cycle issue_valid=1, alu_control=0001, operand_1=1,
//   operand_2=18, gpr_destination_address=3, reg_write=1, immediate_value=0.
// - instr=32'h20251212 -> alu_control=0011, operand_1=1, gpr_destination_address=5,
//   immediate_value=16'h1212, operand_2=0.
// - instr=32'h08000021 pc=32'h40000000 -> redirect_valid one cycle, redirect_pc=32'h40000084,
//   instr_ready=0 that cycle; uop alu_control=0100, gpr_destination_address=32'h21, reg_write=0.
// - issue_ready=0, stream add,sub (32'h00321822),add -> ready drops after 2 accepts; release ->
//   issue order add,sub,add, no loss/duplicate; then 32'h0 NOP -> nothing issued.
// - 32'hFC000000 with ILLEGAL_TRAP_EN -> illegal_trap=1, instr_ready stays 0 until rst;
//   without macro -> dropped, following add issues normally.
// - Assert rst while queue full and FLUSH active -> issue_valid=0, redirect_valid=0, queue empty.

Source files
------------

// File: rtl/decode_issue_unit.sv
// decode_issue_unit: decodes MIPS-style R/I/J instruction words into
// execute_unit control fields, buffers them in a small FIFO and issues them
// over valid/ready. A decoded jump produces a one-cycle redirect to fetch.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky trap on illegal words).
module decode_issue_unit #(
    parameter int QUEUE_DEPTH = 2,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] instr_pc,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [4:0]      operand_1,
    output logic [4:0]      operand_2,
    output logic [31:0]     gpr_destination_address,
    output logic [3:0]      alu_control,
    output logic            reg_write,
    output logic [15:0]     immediate_value,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            illegal_trap
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  op1;
        logic [4:0]  op2;
        logic [31:0] dst;
        logic [15:0] imm;
        logic        rw;
    } uop_t;

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_TRAP = 2'd2} state_t;

    state_t            state;
    uop_t              mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [PC_W-1:0]   redirect_pc_p1;

    uop_t  dec_p0;
    logic  is_add, is_sub, is_addi, is_jump, is_nop, legal, illegal;
    logic  accept, push, pop;

    // Decode the presented word into a uop and classify it
    always_comb begin
        is_add  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b100000);
        is_sub  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b100010);
        is_addi = (instr[31:26] == 6'b001000);
        is_jump = (instr[31:26] == 6'b000010);
        is_nop  = (instr == 32'h0);
        legal   = is_add || is_sub || is_addi || is_jump;
        illegal = !legal && !is_nop;
        dec_p0     = '0;
        dec_p0.op1 = instr[25:21];
        if (is_add || is_sub) begin
            dec_p0.alu = is_add ? 4'b0001 : 4'b0010;
            dec_p0.op2 = instr[20:16];
            dec_p0.dst = {27'b0, instr[15:11]};
            dec_p0.rw  = 1'b1;
        end else if (is_addi) begin
            dec_p0.alu = 4'b0011;
            dec_p0.dst = {27'b0, instr[20:16]};
            dec_p0.imm = instr[15:0];
            dec_p0.rw  = 1'b1;
        end else if (is_jump) begin
            dec_p0.alu = 4'b0100;
            dec_p0.dst = {6'b0, instr[25:0]};
        end
    end

    // Handshake: no bypass, a full queue refuses input even while draining
    assign instr_ready = !rst && (count < DEPTH_C) && (state == ST_RUN);
    assign accept      = instr_valid && instr_ready;
    assign push        = accept && legal;
    assign issue_valid = (count != '0);
    assign pop         = issue_valid && issue_ready;

    // Control FSM: RUN, one-cycle FLUSH after a jump, optional sticky TRAP
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && is_jump) begin
                        state          <= ST_FLUSH;
                        redirect_valid <= 1'b1;
                    end
`ifdef ILLEGAL_TRAP_EN
                    else if (accept && illegal) begin
                        state <= ST_TRAP;
                    end
`endif
                end
                ST_FLUSH: begin
                    state          <= ST_RUN;
                    redirect_valid <= 1'b0;
                end
                default: state <= state;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_p1;
    logic unused_ok;
    assign unused_ok = ^{instr_pc[27:0]};

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            trap_p1 <= 1'b0;
        else if (state == ST_RUN && accept && illegal)
            trap_p1 <= 1'b1;
    end
    assign illegal_trap = trap_p1;
`else
    logic unused_ok;
    assign unused_ok    = ^{instr_pc[27:0], illegal};
    assign illegal_trap = 1'b0;
`endif

    // Jump target capture; only visible while redirect_valid is high
    always_ff @(posedge clk) begin
        if (accept && is_jump)
            redirect_pc_p1 <= {instr_pc[PC_W-1:28], instr[25:0], 2'b00};
    end
    assign redirect_pc = redirect_valid ? redirect_pc_p1 : '0;

    // FIFO control: pointers wrap naturally for power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec_p0;
    end

    // Issue fields read zero whenever nothing is being offered
    always_comb begin
        uop_t head;
        head = issue_valid ? mem[rd_ptr] : '0;
        alu_control             = head.alu;
        operand_1               = head.op1;
        operand_2               = head.op2;
        gpr_destination_address = head.dst;
        immediate_value         = head.imm;
        reg_write               = head.rw;
    end
endmodule
